// File: rtl/pingpong_pkg.sv
// Shared types and pointer-width helpers for the ping-pong width-converting buffer.
// Pointer widths clamp to 1 bit so single-word banks still elaborate.
package pingpong_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int wr_cnt_w(input int bank_depth);
    return (bank_depth > 1) ? $clog2(bank_depth) : 1;
  endfunction

  function automatic int rd_cnt_w(input int bank_depth, input int ratio);
    return ((bank_depth / ratio) > 1) ? $clog2(bank_depth / ratio) : 1;
  endfunction

endpackage

// File: rtl/pingpong_mem.sv
// Narrow-write / RATIO-wide registered-read storage; read data valid 1 cycle after rd_en, held otherwise.
// Lane order: LSB-first by default, MSB-first (entry k in lane RATIO-1-k) with PINGPONG_MSB_FIRST_EN.
module pingpong_mem #(
  parameter int WR_WIDTH = 8,
  parameter int RATIO    = 2,
  parameter int DEPTH    = 128,
  parameter int AW       = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_en,
  input  logic [AW-1:0]             wr_addr,
  input  logic [WR_WIDTH-1:0]       wr_data,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [WR_WIDTH*RATIO-1:0] rd_data
);

  logic [WR_WIDTH-1:0]       mem_q [DEPTH];
  logic [WR_WIDTH*RATIO-1:0] rd_data_q;
  logic [WR_WIDTH*RATIO-1:0] rd_data_d;

  // The array itself is never reset; the bank FSMs keep stale entries unreadable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      for (int k = 0; k < RATIO; k++) begin
`ifdef PINGPONG_MSB_FIRST_EN
        rd_data_d[(RATIO-1-k)*WR_WIDTH +: WR_WIDTH] = mem_q[rd_addr + AW'(k)];
`else
        rd_data_d[k*WR_WIDTH +: WR_WIDTH] = mem_q[rd_addr + AW'(k)];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/pingpong_wbuf.sv
// Two-bank ping-pong buffer: narrow writes fill one bank while the other drains as RATIO-wide words, 1-cycle read latency.
// wr_ready drops when the write bank is FULL/DRAINING (rejects flag sticky wr_ovf); lane order via PINGPONG_MSB_FIRST_EN.
module pingpong_wbuf
  import pingpong_pkg::*;
#(
  parameter int WR_WIDTH   = 8,
  parameter int RATIO      = 2,
  parameter int BANK_DEPTH = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [WR_WIDTH-1:0]       wr_data,
  output logic                      wr_ovf,
  output logic                      rd_avail,
  input  logic                      rd_req,
  output logic                      rd_valid,
  output logic [WR_WIDTH*RATIO-1:0] rd_data,
  output logic                      rd_last
);

  localparam int WCW   = wr_cnt_w(BANK_DEPTH);
  localparam int RCW   = rd_cnt_w(BANK_DEPTH, RATIO);
  localparam int AW    = $clog2(2 * BANK_DEPTH);
  localparam int WORDS = BANK_DEPTH / RATIO;

  bank_state_t    bank_q [2];
  bank_state_t    bank_d [2];
  logic           wr_bank_q, wr_bank_d;
  logic [WCW-1:0] wr_cnt_q,  wr_cnt_d;
  logic           rd_bank_q, rd_bank_d;
  logic [RCW-1:0] rd_cnt_q,  rd_cnt_d;
  logic           wr_ovf_q,  wr_ovf_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q,  rd_last_d;

  logic           wr_acc;
  logic           rd_acc;
  logic           wr_last_word;
  logic           rd_last_word;
  logic [AW-1:0]  mem_wr_addr;
  logic [AW-1:0]  mem_rd_addr;

  assign wr_ready     = (bank_q[wr_bank_q] == EMPTY) || (bank_q[wr_bank_q] == FILLING);
  assign rd_avail     = (bank_q[rd_bank_q] == FULL)  || (bank_q[rd_bank_q] == DRAINING);
  assign wr_acc       = wr_valid && wr_ready;
  assign rd_acc       = rd_req && rd_avail;
  assign wr_last_word = (wr_cnt_q == WCW'(BANK_DEPTH - 1));
  assign rd_last_word = (rd_cnt_q == RCW'(WORDS - 1));

  assign mem_wr_addr = AW'(wr_bank_q) * AW'(BANK_DEPTH) + AW'(wr_cnt_q);
  assign mem_rd_addr = AW'(rd_bank_q) * AW'(BANK_DEPTH) + AW'(rd_cnt_q) * AW'(RATIO);

  // Write and read sides only ever touch different banks, so both updates apply in one cycle.
  always_comb begin
    bank_d     = bank_q;
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_bank_d  = rd_bank_q;
    rd_cnt_d   = rd_cnt_q;
    wr_ovf_d   = wr_ovf_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;

    if (flush) begin
      bank_d[0] = EMPTY;
      bank_d[1] = EMPTY;
      wr_bank_d = 1'b0;
      wr_cnt_d  = '0;
      rd_bank_d = 1'b0;
      rd_cnt_d  = '0;
      wr_ovf_d  = 1'b0;
    end else begin
      if (wr_valid && !wr_ready) begin
        wr_ovf_d = 1'b1;
      end

      if (wr_acc) begin
        if (wr_last_word) begin
          bank_d[wr_bank_q] = FULL;
          wr_cnt_d          = '0;
          wr_bank_d         = ~wr_bank_q;
        end else begin
          bank_d[wr_bank_q] = FILLING;
          wr_cnt_d          = wr_cnt_q + 1'b1;
        end
      end

      if (rd_acc) begin
        rd_valid_d = 1'b1;
        rd_last_d  = rd_last_word;
        if (rd_last_word) begin
          bank_d[rd_bank_q] = EMPTY;
          rd_cnt_d          = '0;
          rd_bank_d         = ~rd_bank_q;
        end else begin
          bank_d[rd_bank_q] = DRAINING;
          rd_cnt_d          = rd_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0]  <= EMPTY;
      bank_q[1]  <= EMPTY;
      wr_bank_q  <= 1'b0;
      wr_cnt_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_cnt_q   <= '0;
      wr_ovf_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      bank_q     <= bank_d;
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_bank_q  <= rd_bank_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_ovf_q   <= wr_ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  // Gated by flush so a flushed read leaves rd_data holding its last value.
  pingpong_mem #(
    .WR_WIDTH (WR_WIDTH),
    .RATIO    (RATIO),
    .DEPTH    (2 * BANK_DEPTH),
    .AW       (AW)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_acc && !flush),
    .wr_addr (mem_wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_acc && !flush),
    .rd_addr (mem_rd_addr),
    .rd_data (rd_data)
  );

  assign wr_ovf   = wr_ovf_q;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;

endmodule

// File: tb/tb_pingpong_wbuf.sv
// Random and directed stimulus against a queue-based model of the two-bank buffer.
module tb_pingpong_wbuf;

  localparam int W     = 8;
  localparam int R     = 2;
  localparam int D     = 64;
  localparam int WORDS = D / R;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           flush = 1'b0;
  logic           wr_valid = 1'b0;
  logic           wr_ready;
  logic [W-1:0]   wr_data = '0;
  logic           wr_ovf;
  logic           rd_avail;
  logic           rd_req = 1'b0;
  logic           rd_valid;
  logic [W*R-1:0] rd_data;
  logic           rd_last;

  logic           r4_wr_valid = 1'b0;
  logic           r4_wr_ready;
  logic [7:0]     r4_wr_data = '0;
  logic           r4_wr_ovf;
  logic           r4_rd_avail;
  logic           r4_rd_req = 1'b0;
  logic           r4_rd_valid;
  logic [31:0]    r4_rd_data;
  logic           r4_rd_last;

  always #5 clk = ~clk;

  pingpong_wbuf #(.WR_WIDTH(W), .RATIO(R), .BANK_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_ovf(wr_ovf),
    .rd_avail(rd_avail), .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_last(rd_last)
  );

  pingpong_wbuf #(.WR_WIDTH(8), .RATIO(4), .BANK_DEPTH(8)) dut_r4 (
    .clk(clk), .rst_n(rst_n), .flush(1'b0),
    .wr_valid(r4_wr_valid), .wr_ready(r4_wr_ready), .wr_data(r4_wr_data), .wr_ovf(r4_wr_ovf),
    .rd_avail(r4_rd_avail), .rd_req(r4_rd_req), .rd_valid(r4_rd_valid), .rd_data(r4_rd_data),
    .rd_last(r4_rd_last)
  );

  int checks = 0;
  int errors = 0;

  // Model: completed banks are a byte stream awaiting readout; nb counts banks that are full or draining.
  int             nb = 0;
  int             rd_words = 0;
  bit [W-1:0]     rdq[$];
  bit [W-1:0]     fillq[$];
  bit             exp_valid = 0;
  bit             exp_last = 0;
  bit             exp_ovf = 0;
  logic [W*R-1:0] exp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [W*R-1:0] pop_word();
    logic [W*R-1:0] w;
    w = '0;
    for (int k = 0; k < R; k++) begin
`ifdef PINGPONG_MSB_FIRST_EN
      w[(R-1-k)*W +: W] = rdq.pop_front();
`else
      w[k*W +: W] = rdq.pop_front();
`endif
    end
    return w;
  endfunction

  function automatic logic [15:0] pair(input logic [7:0] first, input logic [7:0] second);
`ifdef PINGPONG_MSB_FIRST_EN
    return {first, second};
`else
    return {second, first};
`endif
  endfunction

  task automatic model_clear();
    nb = 0;
    rd_words = 0;
    rdq.delete();
    fillq.delete();
    exp_valid = 0;
    exp_last = 0;
    exp_ovf = 0;
  endtask

  // One clock cycle: called at posedge+1, returns at the next posedge+1.
  task automatic cycle(input bit wv, input logic [W-1:0] wd, input bit rr, input bit fl);
    bit was_ready;
    bit wacc;
    bit racc;
    wr_valid = wv;
    wr_data  = wd;
    rd_req   = rr;
    flush    = fl;
    #2;
    check("wr_ready", wr_ready, (nb < 2));
    check("rd_avail", rd_avail, (nb > 0));
    was_ready = (nb < 2);
    wacc = wv && was_ready;
    racc = rr && (nb > 0);
    if (fl) begin
      model_clear();
    end else begin
      exp_valid = racc;
      exp_last  = 0;
      if (racc) begin
        exp_data = pop_word();
        rd_words++;
        if (rd_words == WORDS) begin
          exp_last = 1;
          rd_words = 0;
          nb--;
        end
      end
      if (wacc) begin
        fillq.push_back(wd);
        if (fillq.size() == D) begin
          foreach (fillq[i]) rdq.push_back(fillq[i]);
          fillq.delete();
          nb++;
        end
      end
      if (wv && !was_ready) exp_ovf = 1;
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    flush    = 1'b0;
    check("rd_valid", rd_valid, exp_valid);
    check("rd_last",  rd_last,  exp_last);
    check("rd_data",  rd_data,  exp_data);
    check("wr_ovf",   wr_ovf,   exp_ovf);
  endtask

  task automatic do_reset();
    wr_valid = 0; rd_req = 0; flush = 0;
    r4_wr_valid = 0; r4_rd_req = 0;
    rst_n = 1'b0;
    #1;
    check("rst_wr_ready", wr_ready, 1);
    check("rst_wr_ovf",   wr_ovf,   0);
    check("rst_rd_avail", rd_avail, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data",  rd_data,  0);
    check("rst_rd_last",  rd_last,  0);
    model_clear();
    exp_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic r4_step(input bit wv, input logic [7:0] wd, input bit rr);
    r4_wr_valid = wv;
    r4_wr_data  = wd;
    r4_rd_req   = rr;
    @(posedge clk);
    #1;
    r4_wr_valid = 0;
    r4_rd_req   = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    #2;
    do_reset();

    // Fill one bank with 0x00..0x3F, then drain it.
    for (int i = 0; i < D; i++) begin
      cycle(1, W'(i), 0, 0);
      if (i == D - 2) check("p1_avail_before_full", rd_avail, 0);
    end
    check("p1_avail_after_full", rd_avail, 1);
    check("p1_ready_other_bank", wr_ready, 1);
    for (int i = 0; i < WORDS; i++) begin
      cycle(0, '0, 1, 0);
      check("p1_word", rd_data, pair(8'(2*i), 8'(2*i+1)));
      check("p1_last", rd_last, (i == WORDS - 1));
      if (i == 0) check("p1_first_word", rd_data, pair(8'h00, 8'h01));
      if (i == WORDS - 1) check("p1_final_word", rd_data, pair(8'h3E, 8'h3F));
    end
    cycle(0, '0, 0, 0);
    check("p1_drained_avail", rd_avail, 0);

    // Both banks full, then an overflow write that must be dropped.
    for (int i = 0; i < 2 * D; i++) cycle(1, 8'(i * 3 + 7), 0, 0);
    check("p2_ready_low", wr_ready, 0);
    cycle(1, 8'hEE, 0, 0);
    check("p2_ovf_set", wr_ovf, 1);
    for (int i = 0; i < 2 * WORDS; i++) begin
      cycle(0, '0, 1, 0);
      if (i == 0) check("p2_first_word", rd_data, pair(8'h07, 8'h0A));
    end
    check("p2_ovf_sticky", wr_ovf, 1);
    cycle(0, '0, 0, 1);
    check("p2_ovf_flushed", wr_ovf, 0);

    // Flush in the middle of a fill discards the partial bank.
    for (int i = 0; i < 20; i++) cycle(1, 8'($urandom), 0, 0);
    cycle(0, '0, 1, 1);
    check("fl_avail", rd_avail, 0);
    check("fl_ready", wr_ready, 1);
    for (int i = 0; i < D; i++) begin
      cycle(1, 8'(8'h40 + i), 0, 0);
      if (i == D - 2) check("fl_avail_63", rd_avail, 0);
    end
    check("fl_avail_64", rd_avail, 1);
    for (int i = 0; i < WORDS; i++) begin
      cycle(0, '0, 1, 0);
      if (i == 0) check("fl_first_word", rd_data, pair(8'h40, 8'h41));
    end

    // Continuous streaming.
    for (int i = 0; i < 1024; i++) cycle(1, 8'($urandom), 1, 0);
    check("stream_no_ovf", wr_ovf, 0);

    // Random traffic with varying rates and rare flushes.
    for (int i = 0; i < 3000; i++) begin
      bit wv, rr, fl;
      if (i < 1500) begin
        wv = ($urandom_range(0, 9) < 8);
        rr = ($urandom_range(0, 9) < 3);
      end else begin
        wv = ($urandom_range(0, 9) < 4);
        rr = ($urandom_range(0, 9) < 8);
      end
      fl = ($urandom_range(0, 299) == 0);
      cycle(wv, 8'($urandom), rr, fl);
    end

    // Reset in the middle of a drain.
    cycle(0, '0, 0, 1);
    for (int i = 0; i < D; i++) cycle(1, 8'(i + 100), 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, '0, 1, 0);
    check("mid_drain_valid", rd_valid, 1);
    do_reset();
    check("post_rst_avail", rd_avail, 0);
    check("post_rst_ready", wr_ready, 1);
    for (int i = 0; i < D; i++) cycle(1, 8'($urandom), 0, 0);
    for (int i = 0; i < WORDS + 2; i++) cycle(0, '0, 1, 0);

    // Four-lane instance: 8-entry banks.
    for (int i = 0; i < 8; i++) r4_step(1, 8'(i), 0);
    check("r4_avail", r4_rd_avail, 1);
    r4_step(0, '0, 1);
    check("r4_valid0", r4_rd_valid, 1);
    check("r4_last0",  r4_rd_last,  0);
`ifdef PINGPONG_MSB_FIRST_EN
    check("r4_word0", r4_rd_data, 32'h00010203);
`else
    check("r4_word0", r4_rd_data, 32'h03020100);
`endif
    r4_step(0, '0, 1);
    check("r4_last1",  r4_rd_last,  1);
`ifdef PINGPONG_MSB_FIRST_EN
    check("r4_word1", r4_rd_data, 32'h04050607);
`else
    check("r4_word1", r4_rd_data, 32'h07060504);
`endif
    r4_step(0, '0, 0);
    check("r4_valid_pulse", r4_rd_valid, 0);
    check("r4_drained", r4_rd_avail, 0);
    check("r4_no_ovf", r4_wr_ovf, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
